// File: rtl/ad7680_sample_sched.sv
// AD7680 sample scheduler: periodic/software requests, RD_PULSE-wide conversion triggers, timeout.
// Define AD7680_SCHED_AVG_EN to average 2^cfg_avg_log2 samples per burst; otherwise one raw sample.
module ad7680_sample_sched #(
   parameter int unsigned RD_PULSE    = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] cfg_period,
   input  logic [2:0]  cfg_avg_log2,
   input  logic        sw_req,
   output logic        adc_rd_en,
   input  logic        adc_data_en,
   input  logic [15:0] adc_data,
   output logic        result_valid,
   output logic [15:0] result,
   output logic        result_src,
   output logic        busy,
   output logic        timeout_err,
   input  logic        timeout_clr
);

   localparam int unsigned PulseW = $clog2(RD_PULSE + 1);
   localparam int unsigned WaitW  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {StIdle, StTrig, StWait, StAcc, StDone} state_e;

   state_e              state_q;
   logic [23:0]         per_cnt_q;
   logic                pend_per_q;
   logic                pend_sw_q;
   logic                src_q;
   logic [PulseW-1:0]   pulse_cnt_q;
   logic [WaitW-1:0]    wait_cnt_q;
   logic [15:0]         sample_q;

   logic                per_run;
   logic                per_tick;
   logic                last_smp;
   logic [15:0]         avg_out;

   // >= keeps the counter bounded if cfg_period shrinks below the current count
   assign per_run  = enable && (cfg_period != 24'd0);
   assign per_tick = per_run && (per_cnt_q >= cfg_period - 24'd1);

`ifdef AD7680_SCHED_AVG_EN
   logic [22:0] acc_q;
   logic [7:0]  cnt_q;
   logic [2:0]  log2_q;
   logic [22:0] acc_sum;
   logic [7:0]  cnt_inc;

   assign acc_sum  = acc_q + {7'd0, sample_q};
   assign cnt_inc  = cnt_q + 8'd1;
   assign last_smp = (cnt_inc >= (8'd1 << log2_q));
   assign avg_out  = 16'(acc_sum >> log2_q);
`else
   logic unused_cfg;

   assign unused_cfg = ^cfg_avg_log2;
   assign last_smp   = 1'b1;
   assign avg_out    = sample_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         per_cnt_q    <= '0;
         pend_per_q   <= 1'b0;
         pend_sw_q    <= 1'b0;
         src_q        <= 1'b0;
         pulse_cnt_q  <= '0;
         wait_cnt_q   <= '0;
         sample_q     <= '0;
         adc_rd_en    <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         result_src   <= 1'b0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
`ifdef AD7680_SCHED_AVG_EN
         acc_q        <= '0;
         cnt_q        <= '0;
         log2_q       <= '0;
`endif
      end else begin
         result_valid <= 1'b0;

         if (!per_run || per_tick) per_cnt_q <= '0;
         else                      per_cnt_q <= per_cnt_q + 24'd1;

         if (!per_run)      pend_per_q <= 1'b0;
         else if (per_tick) pend_per_q <= 1'b1;
         if (sw_req)        pend_sw_q  <= 1'b1;

         // a timeout raised below overrides a simultaneous clear
         if (timeout_clr) timeout_err <= 1'b0;

         case (state_q)
            StIdle: begin
               if (pend_sw_q || pend_per_q) begin
                  state_q <= StTrig;
                  busy    <= 1'b1;
                  if (pend_sw_q) begin
                     pend_sw_q <= 1'b0;
                     src_q     <= 1'b1;
                  end else begin
                     pend_per_q <= 1'b0;
                     src_q      <= 1'b0;
                  end
`ifdef AD7680_SCHED_AVG_EN
                  log2_q <= cfg_avg_log2;
`endif
               end
            end
            // first TRIG cycle stays low, guaranteeing a 3-cycle low gap between pulses
            StTrig: begin
               if (!adc_rd_en) begin
                  adc_rd_en   <= 1'b1;
                  pulse_cnt_q <= '0;
               end else if (pulse_cnt_q == PulseW'(RD_PULSE - 1)) begin
                  adc_rd_en  <= 1'b0;
                  wait_cnt_q <= '0;
                  state_q    <= StWait;
               end else begin
                  pulse_cnt_q <= pulse_cnt_q + 1'b1;
               end
            end
            StWait: begin
               if (adc_data_en) begin
                  sample_q <= adc_data;
                  state_q  <= StAcc;
               end else if (wait_cnt_q == WaitW'(TIMEOUT_CYC - 1)) begin
                  timeout_err <= 1'b1;
                  state_q     <= StIdle;
                  busy        <= 1'b0;
`ifdef AD7680_SCHED_AVG_EN
                  acc_q       <= '0;
                  cnt_q       <= '0;
`endif
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            StAcc: begin
`ifdef AD7680_SCHED_AVG_EN
               acc_q <= acc_sum;
               cnt_q <= cnt_inc;
`endif
               if (last_smp) begin
                  result       <= avg_out;
                  result_src   <= src_q;
                  result_valid <= 1'b1;
                  state_q      <= StDone;
               end else begin
                  state_q <= StTrig;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
`ifdef AD7680_SCHED_AVG_EN
               acc_q   <= '0;
               cnt_q   <= '0;
`endif
            end
            default: begin
               state_q   <= StIdle;
               busy      <= 1'b0;
               adc_rd_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
